float_narrow_stream: RTL and testbench
======================================

FLOAT_NARROW_STREAM -- requirements
Module: float_narrow_stream

Interface
REQ-001 SHALL have parameter EXP_IN, default 8, input exponent width.
REQ-002 SHALL have parameter FRAC_IN, default 23, input fraction width.
REQ-003 SHALL have parameter EXP_OUT, default 3, output exponent width (EXP_OUT <= EXP_IN).
REQ-004 SHALL have parameter FRAC_OUT, default 4, output fraction width (FRAC_OUT <= FRAC_IN).
REQ-005 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port inValid  input  1  input word valid.
REQ-008 SHALL have port inReady  output  1  block accepts input this cycle.
REQ-009 SHALL have port inData  input  1+EXP_IN+FRAC_IN  {sign, exponent, fraction}, bias 2^(EXP_IN-1)-1.
REQ-010 SHALL have port outValid  output  1  output word valid.
REQ-011 SHALL have port outReady  input  1  consumer accepts output.
REQ-012 SHALL have port outData  output  1+EXP_OUT+FRAC_OUT  narrowed float, bias 2^(EXP_OUT-1)-1.
REQ-013 SHALL have ports outOverflow, outUnderflow, outInexact  output  1 each  flags qualified by outValid.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 classify/rebias/align with guard+sticky; S2 round-to-nearest-even and pack.
REQ-015 SHALL transfer on valid&&ready at each boundary; latency inValid->outValid exactly 2 cycles with outReady held high; throughput 1 word/cycle.
REQ-016 SHALL drive inReady = !s1Valid || (s1 advances into S2 this cycle); S2 advances when !outValid || outReady; no combinational path inValid->inReady.
REQ-017 SHALL hold outData and flags stable while outValid && !outReady; no word dropped or duplicated.
REQ-018 SHALL treat input exponent 0 as denormal with effective exponent 1-BIAS_IN.
REQ-019 SHALL map NaN -> exponent all ones, fraction MSB set, rest zero, sign preserved; no flags.
REQ-020 SHALL map Inf -> exponent all ones, fraction 0, sign preserved; no flags; zero -> signed zero.
REQ-021 SHALL produce output denormals by right-shifting {1,fraction} with all shifted-out bits ORed into sticky.
REQ-022 SHALL round RNE; fraction carry-out increments exponent; denormal carry to normal is legal.
REQ-023 SHALL, when rounded exponent >= all ones, output signed Inf with outOverflow=1, outInexact=1.
REQ-024 SHALL, when value rounds below half the smallest denormal, output signed zero with outUnderflow=1, outInexact=1.
REQ-025 SHALL set outInexact when guard|sticky nonzero; outUnderflow when result tiny (pre-round exponent below min normal) and inexact.

Reset
REQ-026 SHALL on resetN low clear s1Valid and outValid, drive inReady=1, outData=0, all flags 0, stats counters 0.
REQ-027 SHALL discard in-flight words on reset mid-operation; first post-reset output is the first word accepted after resetN rises.

Configuration
REQ-028 SHALL, with FLOAT_NARROW_STATS_EN defined, add outputs overflowCount, inexactCount (16 bits each) incrementing on each output handshake with the respective flag, saturating at 0xFFFF.
REQ-029 SHALL, without FLOAT_NARROW_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification (defaults 8/23 -> 3/4, outReady=1 unless stated)
REQ-030 SHALL cover 0x3F800000 (1.0) -> outData 0x30 at cycle 2, all flags 0.
REQ-031 SHALL cover 0x3F840000 (1+1/32, tie) -> 0x30 inexact; 0x3F8C0000 (1+3/32, tie) -> 0x32 inexact.
REQ-032 SHALL cover 0x41800000 (16.0) -> 0x70, overflow=1, inexact=1; 0xFFC00000 (NaN) -> 0xF8, no flags.
REQ-033 SHALL cover 0x3C800000 (2^-6) -> 0x01 exact, no flags; 0x33800000 (2^-24) -> 0x00, underflow=1, inexact=1.
REQ-034 SHALL cover back-to-back 4 words with outReady low cycles 3-5 -> inReady low after both stages fill, all 4 outputs in order, held stable while stalled.
REQ-035 SHALL cover resetN pulsed low with 2 words in flight -> outValid 0 immediately; next accepted word appears 2 cycles later; with FLOAT_NARROW_STATS_EN, 0x10000 overflowing inputs leave overflowCount at 0xFFFF.

Source files
------------

// File: rtl/float_narrow_stream.sv
// float_narrow_stream: narrows a wide float to a small float with RNE, 2-cycle latency, 1 word/cycle.
// Valid/ready on both sides, a stalled output holds; define FLOAT_NARROW_STATS_EN for saturating flag counters.
module float_narrow_stream #(
  parameter int EXP_IN   = 8,
  parameter int FRAC_IN  = 23,
  parameter int EXP_OUT  = 3,
  parameter int FRAC_OUT = 4
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [EXP_IN+FRAC_IN:0]   inData,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [EXP_OUT+FRAC_OUT:0] outData,
  output logic                      outOverflow,
  output logic                      outUnderflow,
  output logic                      outInexact
`ifdef FLOAT_NARROW_STATS_EN
  ,
  output logic [15:0]               overflowCount,
  output logic [15:0]               inexactCount
`endif
);

  localparam int EW = EXP_IN + 3;
  localparam int SW = FRAC_IN + 3;
  localparam int D  = FRAC_IN - FRAC_OUT + 2;
  localparam int MW = EXP_OUT + FRAC_OUT;
  localparam logic signed [EW-1:0] ONE_S      = EW'(1);
  localparam logic signed [EW-1:0] BIAS_IN_S  = EW'((1 << (EXP_IN - 1)) - 1);
  localparam logic signed [EW-1:0] BIAS_OUT_S = EW'((1 << (EXP_OUT - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX_S     = EW'((1 << EXP_OUT) - 1);
  localparam logic signed [EW-1:0] SW_S       = EW'(SW);
  localparam logic [FRAC_OUT-1:0]  NAN_FRAC   = FRAC_OUT'(1) << (FRAC_OUT - 1);

  logic                in_sign;
  logic [EXP_IN-1:0]   in_exp;
  logic [FRAC_IN-1:0]  in_frac;
  logic                exp_zero, exp_ones, frac_zero, is_normal;
  logic signed [EW-1:0] eo, sh_raw, sh;
  logic [SW-1:0]       sig, shifted;
  logic                lost, guard_c, sticky_c;
  logic [FRAC_OUT-1:0] frac_t;
  logic [MW-1:0]       pre_c;

  logic                s1_valid, s1_sign, s1_nan, s1_inf, s1_zero, s1_ovf, s1_tiny;
  logic                s1_guard, s1_sticky;
  logic [MW-1:0]       s1_pre;
  logic                s2_adv;

  assign in_sign = inData[EXP_IN+FRAC_IN];
  assign in_exp  = inData[FRAC_IN +: EXP_IN];
  assign in_frac = inData[FRAC_IN-1:0];

  assign s2_adv  = !outValid || outReady;
  assign inReady = !s1_valid || s2_adv;

  // S1: rebias, then align so that the output LSB sits at bit D of the shifted significand
  always_comb begin
    exp_zero  = (in_exp == '0);
    exp_ones  = &in_exp;
    frac_zero = (in_frac == '0);
    eo        = (exp_zero ? ONE_S : $signed(EW'(in_exp))) - BIAS_IN_S + BIAS_OUT_S;
    is_normal = !exp_zero && (eo >= ONE_S);
    sh_raw    = ONE_S - eo;
    sh        = '0;
    if (is_normal || sh_raw[EW-1]) sh = '0;
    else if (sh_raw > SW_S)        sh = SW_S;
    else                           sh = sh_raw;
    sig      = {!exp_zero, in_frac, 2'b00};
    shifted  = sig >> $unsigned(sh);
    lost     = |(sig & ~({SW{1'b1}} << $unsigned(sh)));
    guard_c  = shifted[D-1];
    sticky_c = (|shifted[D-2:0]) | lost;
    frac_t   = shifted[D +: FRAC_OUT];
    pre_c    = is_normal ? {eo[EXP_OUT-1:0], frac_t} : {{EXP_OUT{1'b0}}, frac_t};
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_nan    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_ovf    <= 1'b0;
      s1_tiny   <= 1'b0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_pre    <= '0;
    end else if (inReady) begin
      s1_valid <= inValid;
      if (inValid) begin
        s1_sign   <= in_sign;
        s1_nan    <= exp_ones && !frac_zero;
        s1_inf    <= exp_ones && frac_zero;
        s1_zero   <= exp_zero && frac_zero;
        s1_ovf    <= is_normal && (eo >= EMAX_S);
        s1_tiny   <= !shifted[SW-1];
        s1_guard  <= guard_c;
        s1_sticky <= sticky_c;
        s1_pre    <= pre_c;
      end
    end
  end

  // S2: the {exp,frac} add lets a fraction carry ripple into the exponent
  logic [MW:0]   rnd;
  logic          rnd_ovf, nxt_ovf, nxt_unf, nxt_inx;
  logic [MW:0]   nxt_dat;

  assign rnd     = {1'b0, s1_pre} + (MW+1)'(s1_guard & (s1_sticky | s1_pre[0]));
  assign rnd_ovf = rnd[MW] || (&rnd[FRAC_OUT +: EXP_OUT]);

  always_comb begin
    nxt_dat = {s1_sign, rnd[MW-1:0]};
    nxt_inx = s1_guard | s1_sticky;
    nxt_unf = s1_tiny & (s1_guard | s1_sticky);
    nxt_ovf = 1'b0;
    if (s1_nan) begin
      nxt_dat = {s1_sign, {EXP_OUT{1'b1}}, NAN_FRAC};
      nxt_inx = 1'b0;
      nxt_unf = 1'b0;
    end else if (s1_inf || s1_zero) begin
      nxt_dat = s1_inf ? {s1_sign, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b0}}} : {s1_sign, {MW{1'b0}}};
      nxt_inx = 1'b0;
      nxt_unf = 1'b0;
    end else if (s1_ovf || rnd_ovf) begin
      nxt_dat = {s1_sign, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b0}}};
      nxt_ovf = 1'b1;
      nxt_inx = 1'b1;
      nxt_unf = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      outValid     <= 1'b0;
      outData      <= '0;
      outOverflow  <= 1'b0;
      outUnderflow <= 1'b0;
      outInexact   <= 1'b0;
    end else if (s2_adv) begin
      outValid <= s1_valid;
      if (s1_valid) begin
        outData      <= nxt_dat;
        outOverflow  <= nxt_ovf;
        outUnderflow <= nxt_unf;
        outInexact   <= nxt_inx;
      end
    end
  end

`ifdef FLOAT_NARROW_STATS_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      overflowCount <= '0;
      inexactCount  <= '0;
    end else if (outValid && outReady) begin
      if (outOverflow && overflowCount != 16'hFFFF) overflowCount <= overflowCount + 16'd1;
      if (outInexact && inexactCount != 16'hFFFF)   inexactCount  <= inexactCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_float_narrow_stream.sv
// Bench for float_narrow_stream (8/23 -> 3/4): directed vectors, stall/reset scenarios and
// randomized traffic scored against a value-level nearest-even reference.
module tb_float_narrow_stream;
  logic        clock = 1'b0;
  logic        resetN, inValid, inReady, outValid, outReady;
  logic        outOverflow, outUnderflow, outInexact;
  logic [31:0] inData;
  logic [7:0]  outData;
`ifdef FLOAT_NARROW_STATS_EN
  logic [15:0] overflowCount, inexactCount;
`endif

  float_narrow_stream #(.EXP_IN(8), .FRAC_IN(23), .EXP_OUT(3), .FRAC_OUT(4)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady), .inData(inData),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outOverflow(outOverflow), .outUnderflow(outUnderflow), .outInexact(outInexact)
`ifdef FLOAT_NARROW_STATS_EN
    , .overflowCount(overflowCount), .inexactCount(inexactCount)
`endif
  );

  always #5 clock = ~clock;

  // res = {overflow, underflow, inexact, outData}
  typedef struct { logic [31:0] w; bit fixed; logic [10:0] res; } src_t;
  typedef struct { logic [10:0] res; int acc; } exp_t;

  src_t        src_q[$];
  exp_t        exp_q[$];
  src_t        cur;
  bit          have, lat_chk, prev_stall;
  logic [10:0] hold_res;
  int          cyc, n_chk, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r * 0.5;
    return r;
  endfunction

  // magnitude of output code k (k = 112 is the first value past the largest normal)
  function automatic real out_val(input int k);
    int e = k / 16;
    int fr = k % 16;
    return (e == 0) ? real'(fr) * pow2(-6) : real'(16 + fr) * pow2(e - 7);
  endfunction

  function automatic logic [10:0] ref_model(input logic [31:0] w);
    logic s = w[31];
    int   e = int'(w[30:23]);
    int   f = int'(w[22:0]);
    real  x, lo, mid;
    int   k, r;
    if (e == 255) return (f != 0) ? {3'b000, s, 7'b1111000} : {3'b000, s, 7'b1110000};
    if (e == 0 && f == 0) return {3'b000, s, 7'd0};
    x = (e == 0) ? real'(f) * pow2(-149) : real'(f + (1 << 23)) * pow2(e - 150);
    if (x >= out_val(112)) return {3'b101, s, 7'h70};
    k = 0;
    for (int i = 1; i < 112; i++) if (out_val(i) <= x) k = i;
    lo = out_val(k);
    if (x == lo) return {3'b000, s, 7'(k)};
    mid = (lo + out_val(k + 1)) / 2.0;
    if (x < mid)      r = k;
    else if (x > mid) r = k + 1;
    else              r = (k % 2 == 0) ? k : k + 1;
    if (r == 112) return {3'b101, s, 7'h70};
    return {1'b0, (x < pow2(-2)), 1'b1, s, 7'(r)};
  endfunction

  function automatic logic [31:0] rand_word();
    int         cat = int'($urandom_range(9));
    logic       s = 1'($urandom_range(1));
    logic [7:0] e;
    logic [22:0] f = 23'($urandom);
    case (cat)
      0: begin e = 8'hFF; f[0] = 1'b1; end
      1: begin e = 8'hFF; f = '0; end
      2: begin e = 8'h00; f = '0; end
      3: e = 8'h00;
      default: begin
        e = 8'(115 + $urandom_range(20));
        if ($urandom_range(1) == 1) f[17:0] = '0;
      end
    endcase
    return {s, e, f};
  endfunction

  task automatic push_src(input logic [31:0] w, input bit fixed, input logic [10:0] res);
    src_t t;
    t.w = w; t.fixed = fixed; t.res = res;
    src_q.push_back(t);
  endtask

  // one clock: entered and left at posedge+1
  task automatic tick(output bit fired);
    exp_t        e;
    logic [10:0] obs;
    #3;
    obs   = {outOverflow, outUnderflow, outInexact, outData};
    fired = inValid && inReady;
    if (prev_stall) check("hold", 32'({outValid, obs}), 32'({1'b1, hold_res}));
    if (outValid && outReady) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        check("dat", 32'(outData), 32'(e.res[7:0]));
        check("flags", 32'(obs[10:8]), 32'(e.res[10:8]));
        if (lat_chk) check("latency", cyc - e.acc, 2);
      end
    end
    prev_stall = outValid && !outReady;
    hold_res   = obs;
    if (fired) exp_q.push_back('{res: (cur.fixed ? cur.res : ref_model(cur.w)), acc: cyc});
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drive(input int vpct, input int rpct, input int budget);
    bit fired;
    int n = 0;
    while ((src_q.size() > 0 || have || exp_q.size() > 0) && n < budget) begin
      if (!have && src_q.size() > 0 && $urandom_range(99) < vpct) begin
        cur  = src_q.pop_front();
        have = 1'b1;
      end
      inValid  = have;
      inData   = have ? cur.w : $urandom;
      outReady = ($urandom_range(99) < rpct);
      tick(fired);
      if (fired) have = 1'b0;
      n++;
    end
    inValid = 1'b0;
    check("drain", 32'(src_q.size() + exp_q.size() + int'(have)), 0);
  endtask

  task automatic check_reset_state();
    check("rst_in_ready", 32'(inReady), 1);
    check("rst_out_valid", 32'(outValid), 0);
    check("rst_out_data", 32'(outData), 0);
    check("rst_flags", 32'({outOverflow, outUnderflow, outInexact}), 0);
`ifdef FLOAT_NARROW_STATS_EN
    check("rst_counts", 32'({overflowCount, inexactCount}), 0);
`endif
  endtask

  initial begin
    bit fired;
    n_chk = 0; n_err = 0; cyc = 0; have = 0; lat_chk = 0; prev_stall = 0; hold_res = '0;
    resetN = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;
    #2;
    check_reset_state();
    repeat (2) @(posedge clock);
    #2 resetN = 1'b1;
    @(posedge clock);
    #1;

    // directed values with hand-derived results, streamed back to back
    lat_chk = 1'b1;
    push_src(32'h3F800000, 1, {3'b000, 8'h30});
    push_src(32'h3F840000, 1, {3'b001, 8'h30});
    push_src(32'h3F8C0000, 1, {3'b001, 8'h32});
    push_src(32'h41800000, 1, {3'b101, 8'h70});
    push_src(32'hFFC00000, 1, {3'b000, 8'hF8});
    push_src(32'h3C800000, 1, {3'b000, 8'h01});
    push_src(32'h33800000, 1, {3'b011, 8'h00});
    push_src(32'hBF8C0000, 1, {3'b001, 8'hB2});
    push_src(32'h417C0000, 1, {3'b101, 8'h70});
    drive(100, 100, 100);
    lat_chk = 1'b0;

    // four words back to back, consumer stalls for cycles 3..5
    for (int i = 0; i < 4; i++) push_src(32'h3F800000 + (i << 20), 0, '0);
    for (int c = 0; c < 12; c++) begin
      if (!have && src_q.size() > 0) begin cur = src_q.pop_front(); have = 1'b1; end
      inValid  = have;
      inData   = cur.w;
      outReady = !(c >= 3 && c <= 5);
      #1;
      if (c == 4) check("in_ready_full", 32'(inReady), 0);
      tick(fired);
      if (fired) have = 1'b0;
    end
    inValid = 1'b0;
    check("b2b_drain", 32'(exp_q.size() + src_q.size() + int'(have)), 0);

    // randomized traffic with random backpressure, then at full rate
    for (int i = 0; i < 400; i++) push_src(rand_word(), 0, '0);
    drive(70, 60, 8000);
    for (int i = 0; i < 100; i++) push_src(rand_word(), 0, '0);
    drive(100, 100, 2000);

    // reset with two words in flight
    outReady = 1'b0;
    cur.fixed = 1'b0;
    cur.w = 32'h40000000; inValid = 1'b1; inData = cur.w; tick(fired);
    cur.w = 32'h40400000; inData = cur.w; tick(fired);
    inValid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(outValid), 1);
    resetN = 1'b0;
    #1;
    check_reset_state();
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clock);
    #3 resetN = 1'b1;
    @(posedge clock);
    #1;
    lat_chk = 1'b1;
    push_src(32'h3C800000, 1, {3'b000, 8'h01});
    drive(100, 100, 50);
    lat_chk = 1'b0;

`ifdef FLOAT_NARROW_STATS_EN
    resetN = 1'b0;
    #1;
    check("stats_rst", 32'({overflowCount, inexactCount}), 0);
    @(posedge clock);
    #3 resetN = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b1; inData = 32'h7F000000; inValid = 1'b1;
    repeat (3) @(posedge clock);
    #1 inValid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("ovf_count_3", 32'(overflowCount), 3);
    check("inx_count_3", 32'(inexactCount), 3);
    resetN = 1'b0;
    #3 resetN = 1'b1;
    @(posedge clock);
    #1 inValid = 1'b1;
    repeat (32'h10000) @(posedge clock);
    #1 inValid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("ovf_count_sat", 32'(overflowCount), 32'hFFFF);
    check("inx_count_sat", 32'(inexactCount), 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
